// File: rtl/mem_arbiter_2p_if.sv
// Requester-side req/ack bus of mem_arbiter_2p; one instance per port.
// The requester drives req/we/addr/wdata and receives ack/rdata.
interface mem_arbiter_2p_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter sharing one synchronous memory; serialises req/ack accesses.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins) instead of round-robin.
module mem_arbiter_2p #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_2p_if.slave   p0_if,
    mem_arbiter_2p_if.slave   p1_if,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] data_in_o,
    output logic              read_enable_o,
    output logic              write_enable_o,
    input  logic [DATA_W-1:0] data_out_i,
    output logic              busy_o
);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_e;

    state_e            state_q;
    logic              gnt_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] data_in_q;
    logic              re_q, wr_q, busy_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic              last_q;
`endif

    logic              any_req;
    logic              gnt_d;
    logic              win_we_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [DATA_W-1:0] win_wdata_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any_req = p0_if.req | p1_if.req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt_d   = !p0_if.req;
`else
        gnt_d   = (p0_if.req && p1_if.req) ? ~last_q : p1_if.req;
`endif
        win_we_d    = gnt_d ? p1_if.we    : p0_if.we;
        win_addr_d  = gnt_d ? p1_if.addr  : p0_if.addr;
        win_wdata_d = gnt_d ? p1_if.wdata : p0_if.wdata;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            address_q <= '0;
            data_in_q <= '0;
            re_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            // Strobes and acks are single-cycle pulses; the memory bus idles at zero.
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            re_q      <= 1'b0;
            wr_q      <= 1'b0;
            address_q <= '0;
            data_in_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q     <= gnt_d;
                        we_q      <= win_we_d;
                        address_q <= win_addr_d;
                        data_in_q <= win_we_d ? win_wdata_d : '0;
                        re_q      <= !win_we_d;
                        wr_q      <= win_we_d;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        ack0_q  <= !gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q   <= CNT_W'(RD_LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (gnt_q) rdata1_q <= data_out_i;
                        else       rdata0_q <= data_out_i;
                        ack0_q  <= !gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ACK: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_q  <= gnt_q;
`endif
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p0_if.ack      = ack0_q;
    assign p1_if.ack      = ack1_q;
    assign p0_if.rdata    = rdata0_q;
    assign p1_if.rdata    = rdata1_q;
    assign address_o      = address_q;
    assign data_in_o      = data_in_q;
    assign read_enable_o  = re_q;
    assign write_enable_o = wr_q;
    assign busy_o         = busy_q;
endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
Two-port arbiter that shares the single 32x16 synchronous data memory between two requesters. Port 0 is the accumulator sequencer; port 1 is the host/loader that preloads operands and reads back results. Each requester uses a simple req/ack handshake. The arbiter serialises accesses, drives the memory-side Address/ReadEnable/WriteEnable/DataIN, and returns read data to the granted port.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 16, memory data width
RD_LAT, 1, memory read latency in cycles from the ReadEnable cycle to valid DataOut (legal 1..3)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Req0  in  1  port 0 access request
We0  in  1  port 0 write (1) / read (0)
Addr0  in  ADDR_W  port 0 address
WData0  in  DATA_W  port 0 write data
Ack0  out  1  port 0 completion pulse
RData0  out  DATA_W  port 0 read data
Req1, We1, Addr1, WData1, Ack1, RData1  same as port 0, for port 1
Address  out  ADDR_W  memory address
DataIN  out  DATA_W  memory write data
ReadEnable  out  1  memory read strobe
WriteEnable  out  1  memory write strobe
DataOut  in  DATA_W  memory read data
Busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- All outputs are registered. On Reset: every output is 0, state is IDLE, and the last-grant pointer is set to 1, so port 0 wins the first tie.
- States:
  - IDLE: sample Req0/Req1. If any request is present, latch the winner's We/Addr/WData and the grant index, then go to ACCESS.
  - ACCESS (exactly 1 cycle): drive Address. Read: ReadEnable=1. Write: WriteEnable=1 and DataIN=wdata. Then write -> ACK, read -> WAIT.
  - WAIT (RD_LAT cycles, down-counter): at the end of the last WAIT cycle, register DataOut into the granted RDataN, then go to ACK.
  - ACK (1 cycle): AckN=1 for the granted port only. Update the last-grant pointer. Go to IDLE.
- Arbitration is round-robin:
  - One requester -> it wins.
  - Both requesting -> the port not granted last wins.
  - The pointer updates only on completion.
- Latency, with the request seen in IDLE at cycle 0:
  - Write: WriteEnable in cycle 1, Ack in cycle 2.
  - Read: ReadEnable in cycle 1, Ack in cycle 2+RD_LAT.
  - Minimum turnaround is one IDLE cycle between transactions.
- The requester must hold Req/We/Addr/WData stable until Ack. Req still high in the cycle after Ack counts as a new request.
- Req deasserted mid-transaction: the transaction still completes and Ack still pulses. Latched values are used, so later input changes are ignored.
- Outside ACCESS: Address=0, DataIN=0, ReadEnable=0, WriteEnable=0. ReadEnable and WriteEnable are never high together.
- RDataN holds its value until the next read completes on that port. Writes do not alter RDataN.
- Busy=1 in ACCESS, WAIT and ACK.
- Reset mid-transaction: all outputs clear immediately (asynchronous), the transaction is dropped with no Ack, and the state returns to IDLE.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Port 0 always wins when both request; the last-grant pointer is removed. Port 1 can starve while Req0 is held.
- Undefined: round-robin as specified above.

Test Plan:
1. Port 0 only: Req0=1, We0=1, Addr0=5, WData0=0x1234 -> cycle 1 has WriteEnable=1, Address=5, DataIN=0x1234; cycle 2 has Ack0=1 and Ack1=0.
2. Port 1 read with the memory model holding 0xBEEF at address 9, RD_LAT=1 -> ReadEnable in cycle 1, Ack1 in cycle 3, RData1=0xBEEF; RData0 unchanged.
3. Req0 and Req1 both asserted from reset, both held, all reads -> grant order is 0,1,0,1; each Ack is separated by 1 IDLE cycle; no two Acks are ever high in the same cycle.
4. Reset pulsed during the WAIT state of a read -> all outputs read 0 within the same cycle, no Ack follows, and the next request after reset is serviced normally.
5. Req0 dropped in the cycle after IDLE (cycle 1) -> Ack0 still arrives in cycle 2 (write) with the originally latched address and data on the memory bus.
6. With MEM_ARB_FIXED_PRIO_EN defined, Req0 and Req1 held -> only port 0 is granted; after Req0 drops, port 1 is granted on the next IDLE cycle.
